multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a multicycle MIPS-style datapath (lw, sw, R-type,
//   beq, j). Each memory-facing state (FETCH, MEMRD, MEMWR) waits for
//   mem_ready. A wait counter bounds that wait: once it reaches MEM_TIMEOUT
//   with memory still not ready, the FSM parks in ERROR with a sticky fault
//   flag. Only reset leaves ERROR.
//
// Parameters
//   MEM_TIMEOUT   wait cycles tolerated per memory access (1..255)
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   opcode[5:0]   instruction[31:26], valid from DECODE onward
//   mem_ready     memory completes the current access this cycle
//   zero          ALU zero flag (the PC gate for branches lives outside)
//   pcwrite .. alusrca   datapath enables / selects
//   alusrcb[1:0]  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
//   aluop[1:0]    00 add, 01 sub, 10 funct-decoded
//   pcsource[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]    current state code (debug)
//   illegal       one-cycle pulse in DECODE for an unknown opcode
//   fault         sticky memory-timeout flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic [3:0] state,
    output logic       illegal,
    output logic       fault
);

    // State encoding is visible on the debug port, so it is fixed.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ERROR  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    logic [3:0] state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       fault_q, fault_d;

    logic       wait_st;     // state waits on mem_ready
    logic       timed_out;   // counter exhausted and memory still busy
    logic       op_known;

    // The branch condition is applied to pcwritecond outside this block.
    logic       unused_zero;
    assign unused_zero = zero;

    assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
    // mem_ready in the terminal cycle still wins: no timeout then.
    assign timed_out = wait_st && !mem_ready && (wcnt_q == TIMEOUT_W);
    assign op_known  = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                       (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                       (opcode == OP_J);

    // -----------------------------------------------------------------------
    // State register (plus wait counter and sticky fault)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fault_q <= fault_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (timed_out)      state_d = S_ERROR;
                else if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                state_d = S_EXEC;
                else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else                                        state_d = S_FETCH;
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (timed_out)      state_d = S_ERROR;
                else if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (timed_out)      state_d = S_ERROR;
                else if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_FETCH;   // unused codes 11..15 recover
        endcase
    end

    // Counter restarts whenever the FSM moves to a different state, so each
    // memory access (and each fetch) gets a fresh budget. It only counts
    // cycles that a wait state spends holding on a busy memory.
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q)
            wcnt_d = '0;
        else if (wait_st && !mem_ready)
            wcnt_d = wcnt_q + 8'd1;
    end

    assign fault_d = fault_q || (state_d == S_ERROR);

    // -----------------------------------------------------------------------
    // Output logic (Moore, except FETCH's mem_ready qualification and the
    // opcode-dependent illegal pulse in DECODE)
    // -----------------------------------------------------------------------
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                // IR and PC latch only in the cycle memory delivers the word.
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !op_known;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: ;   // ERROR and unused codes: everything off
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule
